// File: rtl/nios2_timer_host_pkg.sv
// Shared definitions for the Nios II interval-timer host controller:
// slave register map, control-register bit positions, bus widths and the
// host FSM state encoding.
package nios2_timer_host_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PERIOD_W = 32;

  // Timer slave register map
  localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PERIOD_H = 3'd3;
  localparam logic [ADDR_W-1:0] REG_SNAP_L   = 3'd4;
  localparam logic [ADDR_W-1:0] REG_SNAP_H   = 3'd5;

  // Control register bit positions
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    RUN,
    WR_STAT,
    GUARD_W,
    WR_STOP,
    SNAP_WR,
    SNAP_RL,
    SNAP_RH,
    SNAP_DONE
  } state_t;

  // Control word that starts the timer with its interrupt enabled
  function automatic logic [DATA_W-1:0] ctrl_start_word(input logic cont);
    logic [DATA_W-1:0] w;
    w                 = '0;
    w[4'(CTRL_ITO)]   = 1'b1;
    w[4'(CTRL_START)] = 1'b1;
    w[4'(CTRL_CONT)]  = cont;
    return w;
  endfunction

  // Control word that stops the timer
  function automatic logic [DATA_W-1:0] ctrl_stop_word();
    logic [DATA_W-1:0] w;
    w                = '0;
    w[4'(CTRL_STOP)] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/nios2_timer_host.sv
// Avalon-MM master that programs, services and snapshots a Nios II style
// interval timer.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_cmd_start         pulse: program i_cmd_period and start the timer
//   i_cmd_period        32-bit period, sampled when i_cmd_start is accepted
//   i_cmd_stop          pulse: stop the timer
//   i_cmd_snap          pulse: snapshot and read back the live counter
//   o_address, o_chipselect, o_write_n, o_writedata, i_readdata
//                       Avalon-MM master (no waitrequest, 1-cycle read latency)
//   i_irq               timer interrupt, level
//   o_busy              high in every state except IDLE and RUN
//   o_running           timer started and not yet stopped / expired
//   o_tick, o_tick_count one pulse and a wrapping count per serviced timeout
//   o_snap_value, o_snap_valid  last snapshot and its update pulse
//
// CONTINUOUS: 1 = periodic timer, 0 = one-shot.
// GUARD: cycles (1..3) spent after a status clear before irq is looked at
// again, so the slave's deasserting irq is not serviced twice.
module nios2_timer_host
  import nios2_timer_host_pkg::*;
#(
  parameter int unsigned CONTINUOUS = 1,
  parameter int unsigned GUARD      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_cmd_start,
  input  logic [31:0] i_cmd_period,
  input  logic        i_cmd_stop,
  input  logic        i_cmd_snap,
  output logic [2:0]  o_address,
  output logic        o_chipselect,
  output logic        o_write_n,
  output logic [15:0] o_writedata,
  input  logic [15:0] i_readdata,
  input  logic        i_irq,
  output logic        o_busy,
  output logic        o_running,
  output logic        o_tick,
  output logic [15:0] o_tick_count,
  output logic [31:0] o_snap_value,
  output logic        o_snap_valid
);

  localparam logic [DATA_W-1:0] CTRL_RUN_WORD  = ctrl_start_word(CONTINUOUS != 0);
  localparam logic [DATA_W-1:0] CTRL_STOP_WORD = ctrl_stop_word();
  localparam logic [1:0]        GUARD_LAST     = 2'(GUARD - 1);

  state_t              r_state,      w_state_d;
  logic [PERIOD_W-1:0] r_period,     w_period_d;
  logic                r_running,    w_running_d;
  logic                r_tick,       w_tick_d;
  logic [15:0]         r_tick_cnt,   w_tick_cnt_d;
  logic [DATA_W-1:0]   r_snap_lo,    w_snap_lo_d;
  logic [31:0]         r_snap_val,   w_snap_val_d;
  logic                r_snap_valid, w_snap_valid_d;
  logic [1:0]          r_guard,      w_guard_d;
  logic                r_stop_seq,   w_stop_seq_d;
  logic                r_snap_ret,   w_snap_ret_d;
  logic                r_busy,       w_busy_d;
  logic [ADDR_W-1:0]   r_addr,       w_addr_d;
  logic                r_cs,         w_cs_d;
  logic                r_wn,         w_wn_d;
  logic [DATA_W-1:0]   r_wd,         w_wd_d;

  // Next state, datapath updates, and bus outputs decoded from the next state
  always_comb begin
    w_state_d      = r_state;
    w_period_d     = r_period;
    w_running_d    = r_running;
    w_tick_d       = 1'b0;
    w_tick_cnt_d   = r_tick_cnt;
    w_snap_lo_d    = r_snap_lo;
    w_snap_val_d   = r_snap_val;
    w_snap_valid_d = 1'b0;
    w_guard_d      = r_guard;
    w_stop_seq_d   = r_stop_seq;
    w_snap_ret_d   = r_snap_ret;
    w_addr_d       = '0;
    w_cs_d         = 1'b0;
    w_wn_d         = 1'b1;
    w_wd_d         = '0;
    w_busy_d       = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_cmd_start) begin
          w_period_d   = i_cmd_period;
          w_tick_cnt_d = '0;
          w_state_d    = WR_PL;
        end else if (i_cmd_snap) begin
          w_snap_ret_d = 1'b0;
          w_state_d    = SNAP_WR;
        end
      end
      RUN: begin
        if (i_cmd_stop) begin
          w_stop_seq_d = 1'b1;
          w_state_d    = WR_STOP;
        end else if (i_irq) begin
          w_stop_seq_d = 1'b0;
          w_tick_d     = 1'b1;
          w_tick_cnt_d = r_tick_cnt + 16'd1;
          w_guard_d    = GUARD_LAST;
          w_state_d    = WR_STAT;
        end else if (i_cmd_start) begin
          w_period_d   = i_cmd_period;
          w_tick_cnt_d = '0;
          w_state_d    = WR_PL;
        end else if (i_cmd_snap) begin
          w_snap_ret_d = 1'b1;
          w_state_d    = SNAP_WR;
        end
      end
      WR_PL:   w_state_d = WR_PH;
      WR_PH: begin
        // running rises on the edge that presents the control write
        w_running_d = 1'b1;
        w_state_d   = WR_CTRL;
      end
      WR_CTRL: w_state_d = RUN;
      WR_STAT: begin
        if (r_stop_seq) begin
          w_stop_seq_d = 1'b0;
          w_running_d  = 1'b0;
          w_state_d    = IDLE;
        end else begin
          w_state_d = GUARD_W;
        end
      end
      GUARD_W: begin
        if (r_guard == 2'd0) begin
          if (CONTINUOUS != 0) begin
            w_state_d = RUN;
          end else begin
            w_running_d = 1'b0;
            w_state_d   = IDLE;
          end
        end else begin
          w_guard_d = r_guard - 2'd1;
        end
      end
      WR_STOP: w_state_d = WR_STAT;
      SNAP_WR: w_state_d = SNAP_RL;
      SNAP_RL: w_state_d = SNAP_RH;
      SNAP_RH: begin
        // readdata now carries the low half requested in SNAP_RL
        w_snap_lo_d = i_readdata;
        w_state_d   = SNAP_DONE;
      end
      SNAP_DONE: begin
        // high half arrives one cycle after SNAP_RH; publish both halves at once
        w_snap_val_d   = {i_readdata, r_snap_lo};
        w_snap_valid_d = 1'b1;
        w_state_d      = r_snap_ret ? RUN : IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    case (w_state_d)
      WR_PL: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_PERIOD_L;
        w_wd_d   = w_period_d[15:0];
      end
      WR_PH: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_PERIOD_H;
        w_wd_d   = w_period_d[31:16];
      end
      WR_CTRL: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_CONTROL;
        w_wd_d   = CTRL_RUN_WORD;
      end
      WR_STAT: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_STATUS;
      end
      WR_STOP: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_CONTROL;
        w_wd_d   = CTRL_STOP_WORD;
      end
      SNAP_WR: begin
        w_cs_d   = 1'b1;
        w_wn_d   = 1'b0;
        w_addr_d = REG_SNAP_L;
      end
      SNAP_RL: begin
        w_cs_d   = 1'b1;
        w_addr_d = REG_SNAP_L;
      end
      SNAP_RH: begin
        w_cs_d   = 1'b1;
        w_addr_d = REG_SNAP_H;
      end
      default: begin
        w_cs_d = 1'b0;
      end
    endcase

    w_busy_d = !((w_state_d == IDLE) || (w_state_d == RUN));
  end

  // State, datapath and bus output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_period     <= '0;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_cnt   <= '0;
      r_snap_lo    <= '0;
      r_snap_val   <= '0;
      r_snap_valid <= 1'b0;
      r_guard      <= '0;
      r_stop_seq   <= 1'b0;
      r_snap_ret   <= 1'b0;
      r_busy       <= 1'b0;
      r_addr       <= '0;
      r_cs         <= 1'b0;
      r_wn         <= 1'b1;
      r_wd         <= '0;
    end else begin
      r_state      <= w_state_d;
      r_period     <= w_period_d;
      r_running    <= w_running_d;
      r_tick       <= w_tick_d;
      r_tick_cnt   <= w_tick_cnt_d;
      r_snap_lo    <= w_snap_lo_d;
      r_snap_val   <= w_snap_val_d;
      r_snap_valid <= w_snap_valid_d;
      r_guard      <= w_guard_d;
      r_stop_seq   <= w_stop_seq_d;
      r_snap_ret   <= w_snap_ret_d;
      r_busy       <= w_busy_d;
      r_addr       <= w_addr_d;
      r_cs         <= w_cs_d;
      r_wn         <= w_wn_d;
      r_wd         <= w_wd_d;
    end
  end

  assign o_address    = r_addr;
  assign o_chipselect = r_cs;
  assign o_write_n    = r_wn;
  assign o_writedata  = r_wd;
  assign o_busy       = r_busy;
  assign o_running    = r_running;
  assign o_tick       = r_tick;
  assign o_tick_count = r_tick_cnt;
  assign o_snap_value = r_snap_val;
  assign o_snap_valid = r_snap_valid;

endmodule

// File: tb/tb_nios2_timer_host.sv
// Directed bench for nios2_timer_host: a periodic instance and a one-shot
// instance, each with a small behavioural timer slave (irq held until the
// status write, registered readback of the snapshot registers).
module tb_nios2_timer_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_period = '0;
  logic        cmd_stop = 1'b0;
  logic        cmd_snap = 1'b0;

  // periodic instance
  logic [2:0]  c_addr;
  logic        c_cs, c_wn, c_busy, c_run, c_tick, c_sv, c_irq, c_irq_r;
  logic        c_irq_raise = 1'b0;
  logic [15:0] c_wd, c_rd, c_tc;
  logic [31:0] c_snap;
  int          c_wr_cnt = 0;

  // one-shot instance
  logic [2:0]  s_addr;
  logic        s_cs, s_wn, s_busy, s_run, s_tick, s_sv, s_irq, s_irq_r;
  logic        s_irq_raise = 1'b0;
  logic [15:0] s_wd, s_rd, s_tc;
  logic [31:0] s_snap;
  int          s_wr_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_timer_host #(.CONTINUOUS(1), .GUARD(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_start(cmd_start), .i_cmd_period(cmd_period),
    .i_cmd_stop(cmd_stop), .i_cmd_snap(cmd_snap),
    .o_address(c_addr), .o_chipselect(c_cs), .o_write_n(c_wn),
    .o_writedata(c_wd), .i_readdata(c_rd), .i_irq(c_irq),
    .o_busy(c_busy), .o_running(c_run), .o_tick(c_tick),
    .o_tick_count(c_tc), .o_snap_value(c_snap), .o_snap_valid(c_sv)
  );

  nios2_timer_host #(.CONTINUOUS(0), .GUARD(1)) dut_os (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_start(cmd_start), .i_cmd_period(cmd_period),
    .i_cmd_stop(cmd_stop), .i_cmd_snap(cmd_snap),
    .o_address(s_addr), .o_chipselect(s_cs), .o_write_n(s_wn),
    .o_writedata(s_wd), .i_readdata(s_rd), .i_irq(s_irq),
    .o_busy(s_busy), .o_running(s_run), .o_tick(s_tick),
    .o_tick_count(s_tc), .o_snap_value(s_snap), .o_snap_valid(s_sv)
  );

  function automatic logic [15:0] slave_rd(input logic [2:0] a);
    if (a == 3'd4) return 16'h1234;
    if (a == 3'd5) return 16'hABCD;
    return 16'h0000;
  endfunction

  // Slave models: irq is held until a status write; a new raise wins
  assign c_irq = c_irq_r | c_irq_raise;
  assign s_irq = s_irq_r | s_irq_raise;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_irq_r <= 1'b0;
      c_rd    <= '0;
    end else begin
      if (c_cs && !c_wn && c_addr == 3'd0) c_irq_r <= 1'b0;
      if (c_irq_raise) c_irq_r <= 1'b1;
      if (c_cs && c_wn) c_rd <= slave_rd(c_addr);
      if (c_cs && !c_wn) c_wr_cnt <= c_wr_cnt + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_irq_r <= 1'b0;
      s_rd    <= '0;
    end else begin
      if (s_cs && !s_wn && s_addr == 3'd0) s_irq_r <= 1'b0;
      if (s_irq_raise) s_irq_r <= 1'b1;
      if (s_cs && s_wn) s_rd <= slave_rd(s_addr);
      if (s_cs && !s_wn) s_wr_cnt <= s_wr_cnt + 1;
    end
  end

  typedef struct {
    logic        start;
    logic [31:0] period;
    logic        stop;
    logic        irq;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        busy;
    logic        run;
    logic        tick;
    logic [15:0] tc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic [31:0] per, input logic sp,
                              input logic iq, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [15:0] wd,
                              input logic b, input logic r, input logic t,
                              input logic [15:0] tc);
    vec_t v;
    v.start = st; v.period = per; v.stop = sp; v.irq = iq;
    v.cs = cs; v.wn = wn; v.addr = a; v.wd = wd;
    v.busy = b; v.run = r; v.tick = t; v.tc = tc;
    return v;
  endfunction

  function automatic logic [39:0] c_pack();
    return {c_cs, c_wn, c_addr, c_wd, c_busy, c_run, c_tick, c_tc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cmd_start   = 1'b0;
    cmd_stop    = 1'b0;
    cmd_snap    = 1'b0;
    c_irq_raise = 1'b0;
    s_irq_raise = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic        saw_tick;
  int          wr_before;

  initial begin
    // cs wn addr wd busy run tick tc
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 16'd0)); // idle after reset
    vq.push_back(mk(1, 32'h000186A0,0, 0, 1, 0, 3'd2, 16'h86A0, 1, 0, 0, 16'd0)); // WR_PL
    vq.push_back(mk(0, 32'h0,       0, 0, 1, 0, 3'd3, 16'h0001, 1, 0, 0, 16'd0)); // WR_PH
    vq.push_back(mk(0, 32'h0,       0, 0, 1, 0, 3'd1, 16'h0007, 1, 1, 0, 16'd0)); // WR_CTRL
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 1, 0, 16'd0)); // RUN
    vq.push_back(mk(0, 32'h0,       0, 1, 1, 0, 3'd0, 16'h0000, 1, 1, 1, 16'd1)); // WR_STAT tick
    vq.push_back(mk(0, 32'h0,       0, 1, 0, 1, 3'd0, 16'h0000, 1, 1, 0, 16'd1)); // GUARD_W ignores irq
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 1, 0, 16'd1)); // RUN
    vq.push_back(mk(0, 32'h0,       0, 0, 1, 0, 3'd0, 16'h0000, 1, 1, 1, 16'd2)); // held irq serviced
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 1, 1, 0, 16'd2));
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 1, 0, 16'd2));
    vq.push_back(mk(0, 32'h0,       0, 1, 1, 0, 3'd0, 16'h0000, 1, 1, 1, 16'd3)); // third tick
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 1, 1, 0, 16'd3));
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 1, 0, 16'd3));
    vq.push_back(mk(0, 32'h0,       1, 1, 1, 0, 3'd1, 16'h0008, 1, 1, 0, 16'd3)); // stop beats irq
    vq.push_back(mk(0, 32'h0,       0, 0, 1, 0, 3'd0, 16'h0000, 1, 1, 0, 16'd3)); // status clear, no tick
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 16'd3)); // IDLE
    vq.push_back(mk(0, 32'h0,       0, 1, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 16'd3)); // irq in IDLE ignored
    vq.push_back(mk(0, 32'h0,       0, 0, 0, 1, 3'd0, 16'h0000, 0, 0, 0, 16'd3));

    do_reset();
    check("reset_c_snap", {31'd0, c_sv, c_snap}, 64'd0);
    foreach (vq[i]) begin
      cmd_start   = vq[i].start;
      cmd_period  = vq[i].period;
      cmd_stop    = vq[i].stop;
      c_irq_raise = vq[i].irq;
      step();
      check($sformatf("vec%0d", i), {24'd0, c_pack()},
            {24'd0, vq[i].cs, vq[i].wn, vq[i].addr, vq[i].wd,
             vq[i].busy, vq[i].run, vq[i].tick, vq[i].tc});
    end

    // Snapshot from RUN, with an irq arriving mid-sequence
    do_reset();
    cmd_start = 1'b1; cmd_period = 32'd5;
    repeat (4) step();
    check("snap_pre_run", {62'd0, c_busy, c_run}, 64'h1);
    cmd_snap = 1'b1;
    step();
    check("snap_wr", {24'd0, c_pack()}, {24'd0, 1'b1, 1'b0, 3'd4, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0});
    c_irq_raise = 1'b1;
    step();
    check("snap_rl", {59'd0, c_cs, c_wn, c_addr}, {59'd0, 1'b1, 1'b1, 3'd4});
    step();
    check("snap_rh", {59'd0, c_cs, c_wn, c_addr}, {59'd0, 1'b1, 1'b1, 3'd5});
    step();
    check("snap_done", {29'd0, c_cs, c_busy, c_sv, c_snap}, {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    step();
    check("snap_value", {29'd0, c_busy, c_run, c_sv, c_snap}, {29'd0, 1'b0, 1'b1, 1'b1, 32'hABCD1234});
    step();
    check("snap_then_irq", {29'd0, c_sv, c_tick, c_cs, c_addr, c_tc},
          {29'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd1});

    // One-shot instance: one timeout ends the run; later irqs are ignored
    do_reset();
    cmd_start = 1'b1; cmd_period = 32'd3;
    repeat (3) step();
    check("os_ctrl_word", {47'd0, s_addr, s_wd}, {47'd0, 3'd1, 16'h0005});
    step();
    check("os_running", {62'd0, s_busy, s_run}, 64'h1);
    s_irq_raise = 1'b1;
    step();
    check("os_tick", {46'd0, s_tick, s_run, s_tc}, {46'd0, 1'b1, 1'b1, 16'd1});
    step();
    step();
    check("os_idle", {61'd0, s_busy, s_run, s_tick}, 64'd0);
    wr_before = s_wr_cnt;
    s_irq_raise = 1'b1;
    saw_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      saw_tick = saw_tick | s_tick | s_cs;
    end
    check("os_irq_ignored", {63'd0, saw_tick}, 64'd0);
    check("os_no_write", 64'(s_wr_cnt - wr_before), 64'd0);
    check("os_tc_hold", {47'd0, s_run, s_tc}, {47'd0, 1'b0, 16'd1});

    // Reset asserted while the period-high write is on the bus
    do_reset();
    cmd_start = 1'b1; cmd_period = 32'hDEADBEEF;
    step();
    check("rst_pl", {44'd0, c_cs, c_addr, c_wd}, {44'd0, 1'b1, 3'd2, 16'hBEEF});
    step();
    check("rst_ph", {43'd0, c_cs, c_run, c_addr, c_wd}, {43'd0, 1'b1, 1'b0, 3'd3, 16'hDEAD});
    reset_n = 1'b0;
    #1;
    check("rst_async", {24'd0, c_pack()}, {24'd0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0});
    check("rst_snap", {31'd0, c_sv, c_snap}, 64'd0);
    wr_before = c_wr_cnt;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step();
    check("rst_no_ctrl", 64'(c_wr_cnt - wr_before), 64'd0);
    check("rst_idle", {24'd0, c_pack()}, {24'd0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_timer_host.md
NIOS2_TIMER_HOST -- requirements
Module: nios2_timer_host

Interface
REQ-001 SHALL have parameter CONTINUOUS, default 1, meaning 1 = timer reloads and runs continuously, 0 = one-shot.
REQ-002 SHALL have parameter GUARD, default 1, meaning idle cycles after a status clear before irq is re-sampled (range 1..3).
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_start  input  1  one-cycle pulse; program and start the timer with cmd_period.
REQ-006 cmd_period  input  32  period value, sampled when cmd_start is accepted.
REQ-007 cmd_stop  input  1  one-cycle pulse; stop the timer.
REQ-008 cmd_snap  input  1  one-cycle pulse; capture and read back the live counter.
REQ-009 address  output  3  Avalon-MM master address (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h).
REQ-010 chipselect  output  1  master chipselect.
REQ-011 write_n  output  1  master write strobe, active-low.
REQ-012 writedata  output  16  master write data.
REQ-013 readdata  input  16  slave read data, valid exactly one cycle after its address is presented with chipselect=1, write_n=1.
REQ-014 irq  input  1  timer interrupt, level.
REQ-015 busy  output  1  high in every state except IDLE and RUN.
REQ-016 running  output  1  high from control-start write until stop or one-shot completion.
REQ-017 tick  output  1  one-cycle pulse per serviced timeout.
REQ-018 tick_count  output  16  serviced timeouts since the last accepted cmd_start; wraps 0xFFFF->0.
REQ-019 snap_value  output  32  last captured counter value; snap_valid  output  1  one-cycle pulse when snap_value updates.

Function
REQ-020 SHALL use FSM states IDLE, WR_PL, WR_PH, WR_CTRL, RUN, WR_STAT, GUARD_W, WR_STOP, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE.
REQ-021 Each WR_* state SHALL be exactly one cycle with chipselect=1, write_n=0; the slave has no waitrequest.
REQ-022 Outside bus states, chipselect SHALL be 0, write_n 1, address 0, writedata 0.
REQ-023 IDLE or RUN, cmd_start: latch cmd_period, clear tick_count, then WR_PL (period[15:0]) -> WR_PH (period[31:16]) -> WR_CTRL -> RUN.
REQ-024 WR_CTRL writedata SHALL be 16'h0005 if CONTINUOUS=0, 16'h0007 if CONTINUOUS=1 (START|CONT|ITO); running set on the same edge.
REQ-025 Priority in RUN: cmd_stop > irq > cmd_start > cmd_snap; commands in busy states SHALL be dropped, not queued.
REQ-026 RUN, irq=1: WR_STAT (address 0, writedata 0), pulse tick and increment tick_count on that edge, then GUARD cycles in GUARD_W.
REQ-027 Leaving GUARD_W: return to RUN if CONTINUOUS=1; if CONTINUOUS=0, clear running and go to IDLE.
REQ-028 RUN, cmd_stop: WR_STOP (address 1, writedata 16'h0008), then WR_STAT, no tick, then IDLE with running=0.
REQ-029 IDLE or RUN, cmd_snap: SNAP_WR (address 4, data 0), SNAP_RL (read address 4), SNAP_RH (read address 5, capture readdata as snap_value[15:0]), SNAP_DONE (capture snap_value[31:16], pulse snap_valid), then return to the state of origin.
REQ-030 irq asserted during a snap sequence SHALL be held by the slave and serviced on return to RUN.
REQ-031 irq in IDLE SHALL be ignored.
REQ-032 cmd_period = 0 SHALL be written unchanged; no special case.

Reset
REQ-033 Asynchronous reset SHALL force IDLE; chipselect 0, write_n 1, address 0, writedata 0, busy 0, running 0, tick 0, tick_count 0, snap_value 0, snap_valid 0, latched period 0.
REQ-034 Reset mid-sequence SHALL abort with no further bus cycle; the slave register state is not repaired.

Structure
REQ-035 A shared package SHALL hold the register-address constants (0..5), control bit positions (ITO 0, CONT 1, START 2, STOP 3), and the FSM state enumeration.
REQ-036 Single module, no sub-modules; the FSM and the bus output register set in one block.

Verification
REQ-037 Reset, then cmd_start with period 0x0001_86A0 -> writes (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles; busy 3 cycles; running=1.
REQ-038 Running, irq held high until write (0,0) -> one tick, tick_count=1, no second tick during GUARD; repeated irqs 3x -> tick_count=3.
REQ-039 irq and cmd_stop in the same RUN cycle -> write (1,0x0008) then (0,0), tick absent, running=0, state IDLE.
REQ-040 cmd_snap with slave returning 0x1234 then 0xABCD -> write (4,0), reads 4 then 5, snap_value=0xABCD1234, one snap_valid pulse, back to RUN.
REQ-041 CONTINUOUS=0, one irq -> one tick then running=0 and IDLE; a later irq is ignored.
REQ-042 reset_n low during WR_PH -> chipselect drops immediately, no WR_CTRL, all outputs at reset values.
